// File: rtl/sel_pkg.sv
// -----------------------------------------------------------------------------
// sel_pkg
// Shared definitions for the sel_ctrl block: the debounce FSM state encoding
// and the default values of the three tuning parameters.
// -----------------------------------------------------------------------------
package sel_pkg;

    // Debounce FSM states. The IDLE_* states hold an accepted level; the
    // WAIT_* states count how long a candidate new level has persisted.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_e;

    // Defaults suit simulation; board builds raise DEBOUNCE_CYCLES to
    // something like 1_000_000.
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int AUTO_PERIOD_DEF     = 8;

endpackage : sel_pkg

// File: rtl/sel_debounce.sv
// -----------------------------------------------------------------------------
// sel_debounce
// Synchronises a raw push-button level, debounces it with a 4-state FSM and
// emits a one-cycle pulse when the debounced level first rises.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   btn_raw    in   raw, asynchronous, bouncing button level
//   stable     out  debounced button level (registered)
//   btn_pulse  out  one-cycle pulse, high in the first cycle stable reads 1
// -----------------------------------------------------------------------------
module sel_debounce
    import sel_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic stable,
    output logic btn_pulse
);

    // Largest count reached is DEBOUNCE_CYCLES-1, so clog2 bits never wrap.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_s;

    deb_state_e             state_q;
    deb_state_e             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   pulse_q;
    logic                   pulse_d;

    // Synchroniser shift: new sample enters at bit 0, s is the oldest stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
        s_s    = sync_q[SYNC_STAGES-1];
    end

    // Debounce next-state, counter and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (s_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!s_s) begin
                    // Bounce: abandon the candidate high level.
                    state_d = IDLE_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HIGH;
                    cnt_d    = CNT_ZERO;
                    stable_d = 1'b1;
                    pulse_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (s_s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    // Release is accepted silently: no pulse.
                    state_d  = IDLE_LOW;
                    cnt_d    = CNT_ZERO;
                    stable_d = 1'b0;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d  = IDLE_LOW;
                cnt_d    = CNT_ZERO;
                stable_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            state_q  <= IDLE_LOW;
            cnt_q    <= CNT_ZERO;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign stable    = stable_q;
    assign btn_pulse = pulse_q;

endmodule : sel_debounce

// File: rtl/sel_ctrl.sv
// -----------------------------------------------------------------------------
// sel_ctrl
// Generates the select line for the downstream 2:1 mux. Each clean button
// press toggles sel; with auto_en set, sel also toggles every AUTO_PERIOD
// cycles so both mux inputs can be observed hands-free.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   btn_raw    in   raw, asynchronous, bouncing button level
//   auto_en    in   synchronous; 1 = periodic toggle mode
//   stable     out  debounced button level
//   btn_pulse  out  one-cycle pulse on debounced rising edge
//   sel        out  mux select (1 = input a, 0 = input b)
// -----------------------------------------------------------------------------
module sel_ctrl
    import sel_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    input  logic auto_en,
    output logic stable,
    output logic btn_pulse,
    output logic sel
);

    localparam int                 AUTO_W    = $clog2(AUTO_PERIOD);
    localparam logic [AUTO_W-1:0]  AUTO_ZERO = {AUTO_W{1'b0}};
    localparam logic [AUTO_W-1:0]  AUTO_ONE  = AUTO_W'(1);
    localparam logic [AUTO_W-1:0]  AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic              stable_s;
    logic              btn_pulse_s;
    logic              tick_s;
    logic [AUTO_W-1:0] auto_cnt_q;
    logic [AUTO_W-1:0] auto_cnt_d;
    logic              sel_q;
    logic              sel_d;

    sel_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw   (btn_raw),
        .stable    (stable_s),
        .btn_pulse (btn_pulse_s)
    );

    // Auto period counter and sel toggle. A press restarts the period, and a
    // press coinciding with a tick still toggles sel only once.
    always_comb begin
        tick_s     = 1'b0;
        auto_cnt_d = auto_cnt_q;
        if (auto_en && (auto_cnt_q == AUTO_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end

        if (!auto_en) begin
            auto_cnt_d = AUTO_ZERO;
        end else if (btn_pulse_s || tick_s) begin
            auto_cnt_d = AUTO_ZERO;
        end else begin
            auto_cnt_d = auto_cnt_q + AUTO_ONE;
        end

        sel_d = sel_q ^ (btn_pulse_s | tick_s);
    end

    // Auto counter and sel registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_cnt_q <= AUTO_ZERO;
            sel_q      <= 1'b0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
            sel_q      <= sel_d;
        end
    end

    assign stable    = stable_s;
    assign btn_pulse = btn_pulse_s;
    assign sel       = sel_q;

endmodule : sel_ctrl

// File: doc/sel_ctrl.md
Name: sel_ctrl

Overview:
- Control stage directly upstream of the 2:1 select mux; generates the mux `sel` line.
- Conditions a raw board push-button: synchronise, debounce, rising-edge detect. Each clean press toggles `sel`.
- Optional auto mode toggles `sel` periodically, so both mux inputs can be observed without pressing.

Parameters:
- SYNC_STAGES, 2, flip-flops in btn_raw synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before acceptance (board builds override, e.g. 1_000_000); minimum 2.
- AUTO_PERIOD, 8, clock cycles between automatic toggles (minimum 2).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw, asynchronous, bouncing button level.
- auto_en  input  1  synchronous; 1 = periodic toggle mode.
- stable  output  1  debounced button level.
- btn_pulse  output  1  one-cycle pulse on stable rising edge.
- sel  output  1  select line to downstream mux (1 = input a, 0 = input b).

Behaviour:
- Reset is asynchronous on the resetn falling edge. While resetn = 0:
  - sync chain = 0, stable = 0, btn_pulse = 0, sel = 0;
  - debounce counter = 0, auto counter = 0, FSM = IDLE_LOW.
- Reset can occur mid-debounce or mid-period. All progress is discarded, with no toggle on release.
- Synchroniser: btn_raw is shifted through SYNC_STAGES flops. The last stage is `s` (internal).
- Debounce FSM, 4 states:
  - IDLE_LOW: stable = 0. If s = 1 -> WAIT_HIGH, counter = 1.
  - WAIT_HIGH:
    - If s = 0 (bounce) -> IDLE_LOW, counter = 0.
    - Else if counter == DEBOUNCE_CYCLES-1 -> IDLE_HIGH, stable <= 1, btn_pulse <= 1.
    - Else counter + 1.
  - IDLE_HIGH: stable = 1. If s = 0 -> WAIT_LOW, counter = 1.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - Acceptance -> IDLE_LOW, stable <= 0.
    - No pulse on release.
- Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- btn_pulse is registered, high exactly one cycle, in the same cycle stable first reads 1.
- Latency: btn_raw held high from before edge 0 -> stable = btn_pulse = 1 after edge SYNC_STAGES+DEBOUNCE_CYCLES-1 (edge 17 at defaults). sel toggles after the next edge (edge 18).
- Auto counter, width clog2(AUTO_PERIOD):
  - auto_en = 0: held at 0.
  - auto_en = 1: increments each edge. At an edge where count == AUTO_PERIOD-1, count <= 0 and a tick occurs.
- sel update: at each edge, sel <= ~sel if btn_pulse (registered) == 1 or tick.
  - Tick and pulse on the same edge -> single toggle, not double.
  - btn_pulse also clears the auto counter, restarting the period.
- auto_en deassert mid-period: counter cleared next edge, sel holds. Re-assert restarts from 0.
- btn_raw activity while auto_en = 1 still toggles sel.

Decomposition:
- Shared package sel_pkg:
  - debounce state enum (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW), 2-bit encoding;
  - default-constant localparams for the three parameters.
- One sub-module sel_debounce (synchroniser + FSM + counter; outputs stable, btn_pulse).
- sel_ctrl top holds the auto counter and the sel register.

Test Plan:
- Reset: resetn = 0 for 3 cycles, btn_raw = 1 -> stable = 0, btn_pulse = 0, sel = 0. Release -> sel still 0 until the debounce completes.
- Clean press, defaults: btn_raw 0->1 before edge 0, held 30 cycles.
  - stable and btn_pulse high after edge 17, btn_pulse low after edge 18.
  - sel = 1 after edge 18.
  - Release held 30 cycles -> stable = 0, no pulse, sel stays 1.
- Bounce: btn_raw toggles every 5 cycles for 40 cycles, then settles high -> exactly one btn_pulse, 17 edges after settling. sel toggles once.
- Auto mode: auto_en = 1 from edge 0, btn_raw = 0 -> sel toggles after edges 7, 15, 23. Drop auto_en at edge 10 -> no toggle at 15; sel holds 1.
- Simultaneous: auto_en = 1 and a press timed so btn_pulse lands on the tick edge -> sel toggles once. Auto counter restarts: next toggle 8 edges later.
- Reset mid-debounce: resetn low during WAIT_HIGH (counter = 9) -> after release, full 16-cycle debounce required. Early stable = 1 is a failure.
